ps2_key_decoder: RTL and testbench

- Sits directly downstream of the PS/2 receiver. Consumes its byte stream (one strobe per received scancode byte) and turns make/break sequences into Tetris game-key state.
- Tracks 0xE0 (extended) and 0xF0 (break) prefixes with a small FSM.
- Outputs per-key held levels and single-cycle press pulses to the game controller, with optional auto-repeat for movement keys.

---
 rtl/tetris_key_pkg.sv | 64 ++++++
 rtl/key_repeat_timer.sv | 34 +++
 rtl/ps2_key_decoder.sv | 106 ++++++++++
 tb/tb_ps2_key_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_key_pkg.sv
// Shared definitions for the PS/2 -> Tetris key decoder.
//   key_idx_e   : bit position of each game key in key_held / key_press
//   ps2_state_e : prefix-tracking FSM states
//   SC_*        : set-2 scancodes the decoder cares about
//   key_decode  : scancode (+ extended flag) -> one-hot key vector, 0 if unmapped
package tetris_key_pkg;

  localparam int NUM_KEYS = 6;

  typedef enum logic [2:0] {
    K_LEFT      = 3'd0,
    K_RIGHT     = 3'd1,
    K_ROTATE    = 3'd2,
    K_SOFT_DROP = 3'd3,
    K_HARD_DROP = 3'd4,
    K_PAUSE     = 3'd5
  } key_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  function automatic logic [NUM_KEYS-1:0] key_decode(input logic [7:0] code, input logic ext);
    logic [NUM_KEYS-1:0] v;
    v = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  v[K_LEFT]      = 1'b1;
        SC_RIGHT: v[K_RIGHT]     = 1'b1;
        SC_UP:    v[K_ROTATE]    = 1'b1;
        SC_DOWN:  v[K_SOFT_DROP] = 1'b1;
        default:  v = '0;
      endcase
    end else begin
      case (code)
        SC_A:     v[K_LEFT]      = 1'b1;
        SC_D:     v[K_RIGHT]     = 1'b1;
        SC_W:     v[K_ROTATE]    = 1'b1;
        SC_S:     v[K_SOFT_DROP] = 1'b1;
        SC_SPACE: v[K_HARD_DROP] = 1'b1;
        SC_ESC:   v[K_PAUSE]     = 1'b1;
        default:  v = '0;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat timer for one movement key.
//   clk, rst : clock, synchronous active-high reset
//   held     : next-cycle held level of the key (drops on the break strobe)
//   press    : accepted-press strobe (same cycle as the make byte)
//   rpt      : repeat strobe, registered into key_press by the parent
// First repeat strobe lands DAS_CYCLES cycles after the press strobe, then
// every ARR_CYCLES. Requires ARR_CYCLES <= DAS_CYCLES.
module key_repeat_timer
  import tetris_key_pkg::*;
#(
  parameter int unsigned DAS_CYCLES = 17_000_000,
  parameter int unsigned ARR_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic held,
  input  logic press,
  output logic rpt
);

  localparam int CW = (DAS_CYCLES > 1) ? $clog2(DAS_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_comb rpt = held && !press && (cnt == CW'(DAS_CYCLES - 1));

  // Reloading to DAS-ARR after a repeat makes the next hit ARR cycles later.
  always_ff @(posedge clk) begin
    if (rst || !held || press) cnt <= '0;
    else if (rpt)              cnt <= CW'(DAS_CYCLES - ARR_CYCLES);
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode stream -> Tetris key state.
//   clk, rst   : clock, synchronous active-high reset
//   scan_code  : byte from PS/2 receiver, valid while scan_valid
//   scan_valid : one-cycle byte strobe
//   key_held   : per-key level, 1 while down
//   key_press  : per-key one-cycle pulse on a new make (and on auto-repeat)
//   key_any    : OR of key_press, same cycle
// Build option KEY_AUTOREPEAT_EN adds DAS/ARR repeat on LEFT, RIGHT, SOFT_DROP.
module ps2_key_decoder
  import tetris_key_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 2_000_000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned DAS_CYCLES = 17_000_000,
  parameter int unsigned ARR_CYCLES = 5_000_000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          scan_code,
  input  logic                scan_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                key_any
);

  localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

  ps2_state_e          state;
  logic [TW-1:0]       tmo;
  logic                is_pfx, ext, is_make, is_brk;
  logic [NUM_KEYS-1:0] hit, press_new, held_nxt, rpt, press_all;

  always_comb begin
    is_pfx    = (scan_code == SC_EXT) || (scan_code == SC_BRK);
    ext       = (state == ST_EXT) || (state == ST_EXT_BRK);
    hit       = key_decode(scan_code, ext);
    is_make   = scan_valid && !is_pfx && ((state == ST_IDLE) || (state == ST_EXT));
    // E0/F0 in EXT_BRK decode as unmapped, so they fall through as a no-op break
    is_brk    = scan_valid && (((state == ST_BRK) && !is_pfx) || (state == ST_EXT_BRK));
    press_new = is_make ? (hit & ~key_held) : '0;
    held_nxt  = (key_held | (is_make ? hit : '0)) & ~(is_brk ? hit : '0);
    press_all = press_new | rpt;
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [NUM_KEYS-1:0] RPT_MASK = 6'b001011; // LEFT, RIGHT, SOFT_DROP

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rpt
    if (RPT_MASK[k]) begin : g_on
      key_repeat_timer #(
        .DAS_CYCLES(DAS_CYCLES),
        .ARR_CYCLES(ARR_CYCLES)
      ) u_rpt (
        .clk  (clk),
        .rst  (rst),
        .held (held_nxt[k]),
        .press(press_new[k]),
        .rpt  (rpt[k])
      );
    end else begin : g_off
      assign rpt[k] = 1'b0;
    end
  end
`else
  assign rpt = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tmo       <= '0;
      key_held  <= '0;
      key_press <= '0;
      key_any   <= 1'b0;
    end else begin
      key_held  <= held_nxt;
      key_press <= press_all;
      key_any   <= |press_all;
      if (scan_valid) begin
        tmo <= '0;
        case (state)
          ST_IDLE: begin
            if (scan_code == SC_EXT)      state <= ST_EXT;
            else if (scan_code == SC_BRK) state <= ST_BRK;
          end
          ST_EXT: begin
            if (scan_code == SC_BRK)      state <= ST_EXT_BRK;
            else if (scan_code != SC_EXT) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;  // break byte or malformed prefix
        endcase
      end else if (state != ST_IDLE) begin
        // stalled prefix: give up so a lost byte can't poison the next key
        if (tmo == TW'(PREFIX_TIMEOUT - 1)) begin
          state <= ST_IDLE;
          tmo   <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int PT  = 16;
  localparam int DAS = 20;
  localparam int ARR = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [5:0] key_held, key_press;
  logic       key_any;

  int vectors = 0;
  int errors  = 0;

  ps2_key_decoder #(
    .PREFIX_TIMEOUT(PT)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .DAS_CYCLES(DAS),
    .ARR_CYCLES(ARR)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .key_held  (key_held),
    .key_press (key_press),
    .key_any   (key_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Key table written from the keyboard map, -1 = unmapped
  function automatic int map_key(input logic [7:0] code, input bit extd);
    if (extd) begin
      case (code)
        8'h6B: return 0;
        8'h74: return 1;
        8'h75: return 2;
        8'h72: return 3;
        default: return -1;
      endcase
    end
    case (code)
      8'h1C: return 0;
      8'h23: return 1;
      8'h1D: return 2;
      8'h1B: return 3;
      8'h29: return 4;
      8'h76: return 5;
      default: return -1;
    endcase
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  longint     cyc = 0;
  bit         m_ext = 0, m_brk = 0;
  longint     m_last = 0;
  logic [5:0] m_held = '0;
  logic [5:0] m_press;
  longint     m_next [6];

  always @(posedge clk) begin
    cyc++;
    m_press = '0;
    if (rst) begin
      m_ext = 0; m_brk = 0; m_held = '0;
    end else begin
      if (scan_valid) begin
        int k;
        // a prefix older than the timeout window has been forgotten
        if ((m_ext || m_brk) && (cyc - m_last > PT)) begin m_ext = 0; m_brk = 0; end
        if (scan_code == 8'hE0 || scan_code == 8'hF0) begin
          if (m_brk) begin
            m_ext = 0; m_brk = 0;
          end else begin
            if (scan_code == 8'hE0) m_ext = 1; else m_brk = 1;
            m_last = cyc;
          end
        end else begin
          k = map_key(scan_code, m_ext);
          if (k >= 0) begin
            if (m_brk) m_held[k] = 1'b0;
            else if (!m_held[k]) begin
              m_held[k] = 1'b1; m_press[k] = 1'b1; m_next[k] = cyc + DAS;
            end
          end
          m_ext = 0; m_brk = 0;
        end
      end
`ifdef KEY_AUTOREPEAT_EN
      foreach (m_next[k]) begin
        if ((k == 0 || k == 1 || k == 3) && m_held[k] && cyc == m_next[k]) begin
          m_press[k] = 1'b1;
          m_next[k]  = m_next[k] + ARR;
        end
      end
`endif
    end
    #1;
    chk("held", 32'(key_held), 32'(m_held));
    chk("press", 32'(key_press), 32'(m_press));
    chk("any", 32'(key_any), 32'(|m_press));
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int offs[$];
    repeat (3) @(negedge clk);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_press", 32'(key_press), 0);
    chk("rst_any", 32'(key_any), 0);
    rst = 1'b0;
    idle(2);

    // A make / break
    send(8'h1C);
    chk("a_press", 32'(key_press), 32'h01);
    chk("a_held", 32'(key_held), 32'h01);
    chk("a_any", 32'(key_any), 1);
    idle(1);
    chk("a_pulse_end", 32'(key_press), 0);
    send(8'hF0); send(8'h1C);
    chk("a_break", 32'(key_held), 0);
    chk("a_break_nopulse", 32'(key_press), 0);

    // extended up
    send(8'hE0); send(8'h75);
    chk("up_press", 32'(key_press), 32'h04);
    chk("up_held", 32'(key_held), 32'h04);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_break", 32'(key_held), 0);
    send(8'hE0); send(8'h21);
    chk("e0_unmapped", 32'(key_held), 0);
    send(8'h1C);
    chk("after_unmapped_idle", 32'(key_press), 32'h01);
    send(8'hF0); send(8'h1C);

    // typematic space
    send(8'h29);
    chk("sp_press1", 32'(key_press), 32'h10);
    idle(3); send(8'h29);
    chk("sp_press2", 32'(key_press), 0);
    idle(3); send(8'h29);
    chk("sp_press3", 32'(key_press), 0);
    chk("sp_held", 32'(key_held), 32'h10);
    send(8'hF0); send(8'h29);
    chk("sp_break", 32'(key_held), 0);

    // prefix timeout
    send(8'hE0); idle(PT + 10); send(8'h6B);
    chk("tmo_abort", 32'(key_held), 0);
    send(8'hE0); idle(5); send(8'h6B);
    chk("tmo_ok_press", 32'(key_press), 32'h01);
    // A shares the LEFT bit; first break clears it
    send(8'h1C);
    chk("shared_nopulse", 32'(key_press), 0);
    send(8'hF0); send(8'h1C);
    chk("shared_break", 32'(key_held), 0);

    // malformed F0 F0, then a fresh make
    send(8'hF0); send(8'hF0); send(8'h76);
    chk("malformed_then_make", 32'(key_press), 32'h20);
    send(8'hF0); send(8'h76);

    // reset between F0 and 1D while W held
    send(8'h1D); send(8'hF0);
    @(negedge clk); rst = 1'b1;
    send(8'h1C);  // ignored under reset
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_held", 32'(key_held), 0);
    send(8'h1D);
    chk("rst_fresh_make", 32'(key_press), 32'h04);
    send(8'hF0); send(8'h1D);
    chk("rst_w_break", 32'(key_held), 0);

`ifdef KEY_AUTOREPEAT_EN
    send(8'h23);
    for (int off = 1; off <= 33; off++) begin
      if (key_press[1]) offs.push_back(off);
      @(negedge clk);
    end
    chk("das_count", 32'(offs.size()), 4);
    if (offs.size() == 4) begin
      chk("das_p0", 32'(offs[0]), 1);
      chk("das_p1", 32'(offs[1]), 21);
      chk("arr_p2", 32'(offs[2]), 26);
      chk("arr_p3", 32'(offs[3]), 31);
    end
    send(8'hF0); send(8'h23);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (key_press[1]) cnt++;
      @(negedge clk);
    end
    chk("rpt_stopped", 32'(cnt), 0);
    send(8'h1C); idle(3); send(8'h23); idle(40);
    send(8'hF0); send(8'h1C); idle(7);
    send(8'hF0); send(8'h23); idle(5);
`endif

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

endmodule
